scancode_filter: RTL and testbench

Parametrised successor to the single-cycle scancode change detector. It consumes PS/2 Set-2 scancode bytes and decodes E0 (extended) and F0 (break) prefixes. Typematic repeats are suppressed or passed according to a mode parameter. Decoded key events are buffered in a small FIFO with a valid/ready output handshake. It sits between the PS/2 byte receiver and any keyboard consumer (display, command decoder).

---
 rtl/scancode_pkg.sv | 30 +++
 rtl/event_fifo.sv | 68 ++++++
 rtl/scancode_filter.sv | 147 ++++++++++++++
 tb/tb_scancode_filter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scancode_pkg.sv
// Shared constants and types for the PS/2 Set-2 scancode filter.
package scancode_pkg;

   localparam logic [7:0] SC_EXT  = 8'hE0;
   localparam logic [7:0] SC_BRK  = 8'hF0;
   localparam logic [7:0] SC_BAT  = 8'hAA;
   localparam logic [7:0] SC_ERR0 = 8'h00;
   localparam logic [7:0] SC_ERR1 = 8'hFF;

   // Prefix decoder states: extended and break prefixes seen so far.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } dec_state_t;

   // One decoded key event; "release" is a reserved word, hence is_release.
   typedef struct packed {
      logic       extended;
      logic       is_release;
      logic [7:0] code;
   } key_event_t;

   // Bytes the keyboard sends for errors or self-test completion; never keys.
   function automatic logic is_err_code(input logic [7:0] b);
      return (b == SC_ERR0) || (b == SC_ERR1) || (b == SC_BAT);
   endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead FIFO with simultaneous push/pop, parametrised on depth and element type.
module event_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  T     wr_data,
   output T     rd_data,
   output logic valid,
   output logic full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T              mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          full_s;
   logic          rd_en_s;
   logic          wr_en_s;

   assign full_s  = (count_r == CW'(DEPTH));
   assign rd_en_s = pop && (count_r != '0);
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign wr_en_s = push && (!full_s || rd_en_s);

   // Storage array; cleared on reset so the head reads zero when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers wrap modulo DEPTH; occupancy tracks push/pop combinations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign valid   = (count_r != '0);
   assign full    = full_s;

endmodule

// File: rtl/scancode_filter.sv
// PS/2 Set-2 scancode decoder with typematic filtering and an event FIFO.
module scancode_filter
   import scancode_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int REPEAT_MODE = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       code_valid,
   input  logic [7:0] code,
   input  logic       evt_ready,
   input  logic       ovf_clr,
   output logic       evt_valid,
   output logic [7:0] evt_code,
   output logic       evt_release,
   output logic       evt_extended,
   output logic       overflow
);

   dec_state_t state_r;
   dec_state_t next_state_s;
   logic       gen_s;
   logic       err_s;
   key_event_t ev_s;

   logic [8:0] held_key_r;
   logic       held_valid_r;
   logic       key_match_s;
   logic       repeat_drop_s;
   logic       emit_s;

   logic       push_r;
   key_event_t push_ev_r;

   key_event_t head_s;
   logic       fifo_valid_s;
   logic       fifo_full_s;
   logic       pop_s;
   logic       ovf_set_s;
   logic       overflow_r;

   // Prefix decode: classify the incoming byte and form a key event.
   always_comb begin
      next_state_s = state_r;
      gen_s        = 1'b0;
      err_s        = 1'b0;
      ev_s         = '0;
      if (code_valid) begin
         if (is_err_code(code)) begin
            next_state_s = S_IDLE;
            err_s        = 1'b1;
         end else if (code == SC_EXT) begin
            next_state_s = S_EXT;
         end else if (code == SC_BRK) begin
            case (state_r)
               S_IDLE:  next_state_s = S_BRK;
               S_EXT:   next_state_s = S_EXT_BRK;
               default: next_state_s = state_r;
            endcase
         end else begin
            gen_s           = 1'b1;
            ev_s.extended   = (state_r == S_EXT) || (state_r == S_EXT_BRK);
            ev_s.is_release = (state_r == S_BRK) || (state_r == S_EXT_BRK);
            ev_s.code       = code;
            next_state_s    = S_IDLE;
         end
      end else begin
         next_state_s = state_r;
      end
   end

   assign key_match_s   = ({ev_s.extended, ev_s.code} == held_key_r);
   assign repeat_drop_s = (REPEAT_MODE == 0) && held_valid_r && key_match_s;
   assign emit_s        = gen_s && (ev_s.is_release || !repeat_drop_s);

   // Decoder state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Held-key tracking for typematic repeat suppression.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_key_r   <= 9'd0;
         held_valid_r <= 1'b0;
      end else if (err_s) begin
         held_valid_r <= 1'b0;
      end else if (gen_s && !ev_s.is_release && !repeat_drop_s) begin
         held_key_r   <= {ev_s.extended, ev_s.code};
         held_valid_r <= 1'b1;
      end else if (gen_s && ev_s.is_release && key_match_s) begin
         held_valid_r <= 1'b0;
      end
   end

   // Decode stage register feeding the FIFO write one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         push_r    <= 1'b0;
         push_ev_r <= '0;
      end else begin
         push_r    <= emit_s;
         push_ev_r <= ev_s;
      end
   end

   assign pop_s = fifo_valid_s && evt_ready;

   event_fifo #(
      .DEPTH (DEPTH),
      .T     (key_event_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_r),
      .pop     (pop_s),
      .wr_data (push_ev_r),
      .rd_data (head_s),
      .valid   (fifo_valid_s),
      .full    (fifo_full_s)
   );

   assign ovf_set_s = push_r && fifo_full_s && !pop_s;

   // Sticky overflow flag; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else if (ovf_set_s) begin
         overflow_r <= 1'b1;
      end else if (ovf_clr) begin
         overflow_r <= 1'b0;
      end
   end

   assign evt_valid    = fifo_valid_s;
   assign evt_code     = head_s.code;
   assign evt_release  = head_s.is_release;
   assign evt_extended = head_s.extended;
   assign overflow     = overflow_r;

endmodule

// File: tb/tb_scancode_filter.sv
// Directed bench for scancode_filter: two instances (repeat suppressed / passed)
// checked every cycle against a queue-based behavioural model.
module tb_scancode_filter;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       code_valid = 1'b0;
   logic [7:0] code = 8'h00;
   logic       evt_ready = 1'b0;
   logic       ovf_clr = 1'b0;

   logic       v0, r0, x0, o0, v1, r1, x1, o1;
   logic [7:0] c0, c1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   scancode_filter #(.DEPTH(DEPTH), .REPEAT_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
      .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(v0), .evt_code(c0),
      .evt_release(r0), .evt_extended(x0), .overflow(o0));

   scancode_filter #(.DEPTH(DEPTH), .REPEAT_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
      .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(v1), .evt_code(c1),
      .evt_release(r1), .evt_extended(x1), .overflow(o1));

   // ---------------- behavioural model ----------------
   // Events encoded {extended, release, code}.
   logic [9:0] mq   [2][$];   // FIFO contents per instance
   logic [9:0] logq [2][$];   // events accepted by the consumer
   logic [9:0] expq [$];
   logic       ext_p, brk_p;  // prefixes seen since the last key byte
   logic       pend_v [2];
   logic [9:0] pend_e [2];
   logic [8:0] held_k [2];
   logic       held_v [2];
   logic       ovf_m  [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ext_p = 1'b0;
      brk_p = 1'b0;
      for (int m = 0; m < 2; m++) begin
         mq[m].delete();
         pend_v[m] = 1'b0;
         pend_e[m] = 10'd0;
         held_k[m] = 9'd0;
         held_v[m] = 1'b0;
         ovf_m[m]  = 1'b0;
      end
   endtask

   // Effect of one rising edge, from the inputs present at that edge.
   task automatic model_step();
      logic       gen, err, set;
      logic [9:0] ev;
      for (int m = 0; m < 2; m++) begin
         set = 1'b0;
         if (mq[m].size() != 0 && evt_ready) begin
            logq[m].push_back(mq[m][0]);
            void'(mq[m].pop_front());
         end
         if (pend_v[m]) begin
            if (mq[m].size() == DEPTH) set = 1'b1;
            else mq[m].push_back(pend_e[m]);
         end
         if (set) ovf_m[m] = 1'b1;
         else if (ovf_clr) ovf_m[m] = 1'b0;
         pend_v[m] = 1'b0;
      end
      gen = 1'b0;
      err = 1'b0;
      ev  = 10'd0;
      if (code_valid) begin
         if (code == 8'h00 || code == 8'hFF || code == 8'hAA) begin
            ext_p = 1'b0; brk_p = 1'b0; err = 1'b1;
         end else if (code == 8'hE0) begin
            ext_p = 1'b1; brk_p = 1'b0;
         end else if (code == 8'hF0) begin
            brk_p = 1'b1;
         end else begin
            gen = 1'b1;
            ev = {ext_p, brk_p, code};
            ext_p = 1'b0; brk_p = 1'b0;
         end
      end
      for (int m = 0; m < 2; m++) begin
         if (err) held_v[m] = 1'b0;
         if (gen) begin
            if (!ev[8]) begin
               if (!(m == 0 && held_v[m] && held_k[m] == {ev[9], ev[7:0]})) begin
                  pend_v[m] = 1'b1; pend_e[m] = ev;
                  held_k[m] = {ev[9], ev[7:0]}; held_v[m] = 1'b1;
               end
            end else begin
               pend_v[m] = 1'b1; pend_e[m] = ev;
               if (held_k[m] == {ev[9], ev[7:0]}) held_v[m] = 1'b0;
            end
         end
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid0", 32'(v0), 32'(mq[0].size() != 0));
         chk("valid1", 32'(v1), 32'(mq[1].size() != 0));
         if (mq[0].size() != 0) chk("head0", 32'({x0, r0, c0}), 32'(mq[0][0]));
         if (mq[1].size() != 0) chk("head1", 32'({x1, r1, c1}), 32'(mq[1][0]));
         chk("ovf0", 32'(o0), 32'(ovf_m[0]));
         chk("ovf1", 32'(o1), 32'(ovf_m[1]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      code_valid = 1'b1;
      code = b;
      step();
      code_valid = 1'b0;
      code = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Compare the consumer log of instance m against expq, then clear it.
   task automatic check_log(input int m, input string name);
      chk({name, "_count"}, 32'(logq[m].size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < logq[m].size(); i++)
         chk(name, 32'(logq[m][i]), 32'(expq[i]));
      logq[m].delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      logq[0].delete();
      logq[1].delete();
      idle(2);
      // Reset values.
      chk("rst_valid", 32'(v0 | v1), 32'd0);
      chk("rst_code", 32'({c0, c1}), 32'd0);
      chk("rst_flags", 32'({r0, x0, o0, r1, x1, o1}), 32'd0);
      rst_n = 1'b1;
      idle(1);

      // Make then break of 1C, with latency checks.
      evt_ready = 1'b1;
      send(8'h1C);
      chk("lat_n", 32'(v0), 32'd0);
      step();
      chk("lat_n1", 32'(v0), 32'd1);
      chk("lat_code", 32'(c0), 32'h1C);
      send(8'hF0); send(8'h1C);
      idle(3);
      expq = '{10'h01C, 10'h11C};
      check_log(0, "mkbrk0"); check_log(1, "mkbrk1");

      // Extended make/break and a duplicated F0 prefix.
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hF0); send(8'hF0); send(8'h1C);
      idle(3);
      expq = '{10'h275, 10'h375, 10'h11C};
      check_log(0, "ext0"); check_log(1, "ext1");

      // Typematic repeat handling.
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
      send(8'hF0); send(8'h1C);
      idle(3);
      expq = '{10'h01C, 10'h11C, 10'h01C, 10'h11C};
      check_log(0, "rep0");
      expq = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C, 10'h11C};
      check_log(1, "rep1");

      // Overflow: six makes with the consumer stalled.
      evt_ready = 1'b0;
      send(8'h15); send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
      idle(2);
      chk("ovf_set", 32'({o0, o1}), 32'h3);
      evt_ready = 1'b1;
      idle(6);
      expq = '{10'h015, 10'h016, 10'h01E, 10'h026};
      check_log(0, "ovf0"); check_log(1, "ovf1");
      chk("ovf_sticky", 32'({o0, o1}), 32'h3);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'({o0, o1}), 32'h0);

      // Full FIFO with push and pop on the same edge.
      evt_ready = 1'b0;
      send(8'h36); send(8'h3D); send(8'h3E); send(8'h46); send(8'h45);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      idle(2);
      chk("full_pp_ovf", 32'({o0, o1}), 32'h0);
      chk("full_pp_valid", 32'({v0, v1}), 32'h3);
      evt_ready = 1'b1;
      idle(6);
      expq = '{10'h036, 10'h03D, 10'h03E, 10'h046, 10'h045};
      check_log(0, "fullpp0"); check_log(1, "fullpp1");

      // Reset in the middle of an E0 F0 prefix.
      send(8'hE0); send(8'hF0);
      do_reset();
      logq[0].delete(); logq[1].delete();
      send(8'h1C);
      idle(3);
      expq = '{10'h01C};
      check_log(0, "midrst0"); check_log(1, "midrst1");

      // AA clears the held key so the following 1C is a fresh make.
      send(8'hAA); send(8'h1C);
      idle(3);
      expq = '{10'h01C};
      check_log(0, "bat0"); check_log(1, "bat1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
